// File: rtl/fe_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fe_decode_queue
//  Description : Back-end decode queue. Buffers decoded instructions from the
//                front end in an ELS_P-deep FIFO and hands them to issue with
//                a valid/yumi handshake. A redirect flushes all wrong-path
//                entries and sends a registered one-cycle mispredict pulse,
//                with the corrected target, back to the front end.
//  Revision    : 1.0 - initial release
// ============================================================================
module fe_decode_queue #(
  parameter int WIDTH_P      = 32,
  parameter int ELS_P        = 8,
  parameter int ADDR_WIDTH_P = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  // front-end side
  input  logic                       valid_i,
  input  logic [WIDTH_P-1:0]         data_i,
  output logic                       ready_o,
  // issue side
  output logic                       valid_o,
  output logic [WIDTH_P-1:0]         data_o,
  input  logic                       yumi_i,
  // redirect from branch resolution
  input  logic                       redirect_i,
  input  logic [ADDR_WIDTH_P-1:0]    redirect_target_i,
  output logic                       mis_predict_o,
  output logic [ADDR_WIDTH_P-1:0]    branch_mis_target_o,
  // occupancy
  output logic [$clog2(ELS_P+1)-1:0] count_o
);

  localparam int c_cnt_w = $clog2(ELS_P + 1);
  localparam int c_ptr_w = (ELS_P > 1) ? $clog2(ELS_P) : 1;
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(ELS_P);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(ELS_P - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

  logic [WIDTH_P-1:0]      r_mem [ELS_P];
  logic [c_ptr_w-1:0]      r_wr_ptr;
  logic [c_ptr_w-1:0]      r_rd_ptr;
  logic [c_cnt_w-1:0]      r_count;
  logic                    r_mis_predict;
  logic [ADDR_WIDTH_P-1:0] r_target;

  logic                    w_enq;
  logic                    w_deq;
  logic [c_ptr_w-1:0]      w_wr_ptr_next;
  logic [c_ptr_w-1:0]      w_rd_ptr_next;

  // Handshake terms depend only on registered state and reset, so ready_o
  // never loops back through the front-end valid.
  assign ready_o = (r_count != c_full) & ~reset_i;
  assign valid_o = (r_count != '0) & ~reset_i;
  assign data_o  = r_mem[r_rd_ptr];

  // Enqueues arriving alongside a redirect, or during the pulse cycle, are
  // stale wrong-path output from the front end and are dropped.
  assign w_enq = valid_i & ready_o & ~redirect_i & ~r_mis_predict;
  assign w_deq = yumi_i & valid_o;

  // Pointers wrap explicitly so ELS_P need not be a power of two.
  assign w_wr_ptr_next = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
  assign w_rd_ptr_next = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;

  assign mis_predict_o       = r_mis_predict;
  assign branch_mis_target_o = r_target;
  assign count_o             = r_count;

  // Storage array: written on accepted enqueue, no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointer, occupancy and redirect-pulse state; a redirect overrides any
  // enqueue/dequeue in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_mis_predict <= 1'b0;
      r_target      <= '0;
    end else begin
      r_mis_predict <= redirect_i;
      if (redirect_i) begin
        r_target <= redirect_target_i;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) begin
          r_wr_ptr <= w_wr_ptr_next;
        end
        if (w_deq) begin
          r_rd_ptr <= w_rd_ptr_next;
        end
        unique case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  // Issue must only consume when an entry is presented.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !valid_o))
        else $error("fe_decode_queue: yumi_i asserted while valid_o is low");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fe_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fe_decode_queue
//  Description : Self-checking bench for fe_decode_queue with a queue-based
//                scoreboard of accepted instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fe_decode_queue;

  localparam int WIDTH_P      = 32;
  localparam int ELS_P        = 8;
  localparam int ADDR_WIDTH_P = 16;

  logic                    clk_i = 1'b0;
  logic                    reset_i;
  logic                    valid_i;
  logic [WIDTH_P-1:0]      data_i;
  logic                    ready_o;
  logic                    valid_o;
  logic [WIDTH_P-1:0]      data_o;
  logic                    yumi_i;
  logic                    redirect_i;
  logic [ADDR_WIDTH_P-1:0] redirect_target_i;
  logic                    mis_predict_o;
  logic [ADDR_WIDTH_P-1:0] branch_mis_target_o;
  logic [3:0]              count_o;

  fe_decode_queue #(
    .WIDTH_P      (WIDTH_P),
    .ELS_P        (ELS_P),
    .ADDR_WIDTH_P (ADDR_WIDTH_P)
  ) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .valid_i             (valid_i),
    .data_i              (data_i),
    .ready_o             (ready_o),
    .valid_o             (valid_o),
    .data_o              (data_o),
    .yumi_i              (yumi_i),
    .redirect_i          (redirect_i),
    .redirect_target_i   (redirect_target_i),
    .mis_predict_o       (mis_predict_o),
    .branch_mis_target_o (branch_mis_target_o),
    .count_o             (count_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model of the queue as seen from outside.
  logic [WIDTH_P-1:0] sb[$];
  int                 m_cnt = 0;
  logic               m_mp  = 1'b0;
  logic [31:0]        seq   = 32'h1000_0000;

  // Drive one cycle of stimulus (reset low), update the model, and compare
  // data_o against the scoreboard head whenever issue consumes.
  task automatic drive(input logic v, input logic [WIDTH_P-1:0] d, input logic y,
                       input logic r, input logic [ADDR_WIDTH_P-1:0] t);
    logic exp_enq;
    logic exp_deq;
    valid_i = v; data_i = d; yumi_i = y; redirect_i = r; redirect_target_i = t;
    exp_enq = v && (m_cnt != ELS_P) && !r && !m_mp;
    exp_deq = y && (m_cnt != 0);
    if (exp_deq) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: model empty at dequeue, data_o=%h", data_o);
      end else begin
        if (data_o !== sb[0]) begin
          errors++;
          $display("FAIL deq_data: data_o=%h expected=%h", data_o, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
    if (r) begin
      sb.delete();
      m_cnt = 0;
      m_mp  = 1'b1;
    end else begin
      if (exp_enq) sb.push_back(d);
      m_cnt = m_cnt + (exp_enq ? 1 : 0) - (exp_deq ? 1 : 0);
      m_mp  = 1'b0;
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0; yumi_i = 1'b0; redirect_i = 1'b0;
  endtask

  task automatic enq_n(input int n);
    for (int i = 0; i < n; i++) begin
      seq = seq + 1;
      drive(1'b1, seq, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic drain;
    int n;
    n = m_cnt;
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (count_o !== 4'd0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: count_o=%0d valid_o=%b expected 0/0", count_o, valid_o);
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1; valid_i = 1'b0; data_i = '0; yumi_i = 1'b0;
    redirect_i = 1'b0; redirect_target_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (count_o !== 4'd0 || valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b ready=%b expected 0/0/0", count_o, valid_o, ready_o);
    end
    checks++;
    if (mis_predict_o !== 1'b0 || branch_mis_target_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_redirect: mis=%b tgt=%h expected 0/0000", mis_predict_o, branch_mis_target_o);
    end
    reset_i = 1'b0;
    sb.delete(); m_cnt = 0; m_mp = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: ready_o=%b expected 1", ready_o);
    end
  endtask

  task automatic test_basic_enq;
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, '0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL first_latency: valid_o=%b data_o=%h expected 1/aaaa0001", valid_o, data_o);
    end
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (count_o !== 4'd3 || ready_o !== 1'b1 || data_o !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL three_enq: count=%0d ready=%b data=%h expected 3/1/aaaa0001", count_o, ready_o, data_o);
    end
    drain();
  endtask

  task automatic test_full;
    enq_n(ELS_P);
    checks++;
    if (ready_o !== 1'b0 || count_o !== 4'd8) begin
      errors++;
      $display("FAIL full_ready: ready=%b count=%0d expected 0/8", ready_o, count_o);
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
    checks++;
    if (count_o !== 4'd7 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_deq_no_write: count=%0d ready=%b expected 7/1", count_o, ready_o);
    end
    drive(1'b1, 32'hFEED_0008, 1'b0, 1'b0, '0);
    checks++;
    if (count_o !== 4'd8) begin
      errors++;
      $display("FAIL full_refill: count=%0d expected 8", count_o);
    end
    drain();
  endtask

  task automatic test_wrap;
    enq_n(1);
    for (int i = 0; i < 20; i++) begin
      seq = seq + 1;
      drive(1'b1, seq, 1'b1, 1'b0, '0);
      checks++;
      if (count_o !== 4'd1) begin
        errors++;
        $display("FAIL wrap_count iter %0d: count=%0d expected 1", i, count_o);
      end
    end
    drain();
  endtask

  task automatic test_flush;
    enq_n(5);
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b1, 16'h0040);
    checks++;
    if (count_o !== 4'd0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: count=%0d valid=%b expected 0/0", count_o, valid_o);
    end
    checks++;
    if (mis_predict_o !== 1'b1 || branch_mis_target_o !== 16'h0040) begin
      errors++;
      $display("FAIL flush_pulse: mis=%b tgt=%h expected 1/0040", mis_predict_o, branch_mis_target_o);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (mis_predict_o !== 1'b0 || branch_mis_target_o !== 16'h0040) begin
      errors++;
      $display("FAIL flush_pulse_end: mis=%b tgt=%h expected 0/0040", mis_predict_o, branch_mis_target_o);
    end
  endtask

  task automatic test_back_to_back;
    enq_n(2);
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b1, 16'h0040);
    checks++;
    if (mis_predict_o !== 1'b1 || branch_mis_target_o !== 16'h0040 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL b2b_first: mis=%b tgt=%h count=%0d expected 1/0040/0", mis_predict_o, branch_mis_target_o, count_o);
    end
    drive(1'b1, 32'h2222_2222, 1'b0, 1'b1, 16'h0080);
    checks++;
    if (mis_predict_o !== 1'b1 || branch_mis_target_o !== 16'h0080 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL b2b_second: mis=%b tgt=%h count=%0d expected 1/0080/0", mis_predict_o, branch_mis_target_o, count_o);
    end
    drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, '0);
    checks++;
    if (count_o !== 4'd0 || mis_predict_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_guard: count=%0d mis=%b expected 0/0", count_o, mis_predict_o);
    end
    drive(1'b1, 32'h4444_4444, 1'b0, 1'b0, '0);
    checks++;
    if (count_o !== 4'd1 || data_o !== 32'h4444_4444) begin
      errors++;
      $display("FAIL b2b_resume: count=%0d data=%h expected 1/44444444", count_o, data_o);
    end
    drain();
  endtask

  task automatic test_reset_mid;
    enq_n(4);
    reset_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 16'h00C0;
    valid_i = 1'b1; data_i = 32'h7777_7777;
    @(posedge clk_i); #1;
    checks++;
    if (count_o !== 4'd0 || mis_predict_o !== 1'b0 || ready_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d mis=%b ready=%b valid=%b expected 0/0/0/0", count_o, mis_predict_o, ready_o, valid_o);
    end
    redirect_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (ready_o !== 1'b0 || branch_mis_target_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: ready=%b tgt=%h expected 0/0000", ready_o, branch_mis_target_o);
    end
    valid_i = 1'b0;
    reset_i = 1'b0;
    sb.delete(); m_cnt = 0; m_mp = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_release: ready=%b count=%0d expected 1/0", ready_o, count_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_enq();
    test_full();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
